// File: rtl/gray_pkg.sv
// gray_pkg: shared width constants and generic Gray/binary conversion helpers
package gray_pkg;
    localparam int GRAY_DEFAULT_WIDTH = 8;
    localparam int GRAY_MAX_WIDTH = 64;

    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g, input int w);
        logic [GRAY_MAX_WIDTH-1:0] b;
        b = g;
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--)
            if (i < w - 1) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b, input int w);
        logic [GRAY_MAX_WIDTH-1:0] g;
        g = b;
        for (int i = 0; i < GRAY_MAX_WIDTH - 1; i++)
            if (i < w - 1) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction
endpackage

// File: rtl/gray_pipe_stage.sv
// gray_pipe_stage: one valid/ready register slice that loads whenever its stage may advance
module gray_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         adv,
    output logic [W-1:0] data,
    output logic         valid
);
    // Slice register; data is only replaced by a valid word so a bubble never clobbers it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (adv) begin
            valid <= in_valid;
            if (in_valid) data <= in_data;
        end
    end
endmodule

// File: rtl/gray_decoder.sv
// gray_decoder: two-stage pipelined Gray-to-binary decoder; GRAY_STEP_CHECK_EN adds a step checker
module gray_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH,
    parameter int SPLIT = WIDTH / 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_gray,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             step_err
);
    logic [WIDTH-1:0] s1_in, s1_data, s2_in;
    logic             s1_v, adv1, adv2;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_v || adv2;
    assign in_ready = adv1;

    // Upper bits decode before stage 1; lower bits finish from b[SPLIT] before stage 2
    always_comb begin
        s1_in = in_gray;
        for (int i = WIDTH - 2; i >= SPLIT; i--) s1_in[i] = s1_in[i+1] ^ in_gray[i];
        s2_in = s1_data;
        for (int i = SPLIT - 1; i >= 0; i--) s2_in[i] = s2_in[i+1] ^ s1_data[i];
    end

    gray_pipe_stage #(.W(WIDTH)) u_s1 (
        .clk(clk), .reset(reset), .in_data(s1_in), .in_valid(in_valid),
        .adv(adv1), .data(s1_data), .valid(s1_v)
    );

    gray_pipe_stage #(.W(WIDTH)) u_s2 (
        .clk(clk), .reset(reset), .in_data(s2_in), .in_valid(s1_v),
        .adv(adv2), .data(out_bin), .valid(out_valid)
    );

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] prev, d;
    logic             have_prev, step_q;

    assign d        = out_bin - prev;
    assign step_err = step_q;

    // Compare each delivered word against the previous one; only 0 or +1 (with wrap) is legal
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev      <= '0;
            have_prev <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            step_q <= out_valid && out_ready && have_prev && (d > WIDTH'(1));
            if (out_valid && out_ready) begin
                prev      <= out_bin;
                have_prev <= 1'b1;
            end
        end
    end
`else
    assign step_err = 1'b0;
`endif
endmodule
